dac_write_sched: RTL and testbench

- Two-requester scheduler for the board's 8-bit dual-channel parallel DAC (csn/wrn/ldacn/a_b/d bus).
- Arbitrates channel-A and channel-B update requests round-robin, captures the granted value, and sequences the bus through setup, write-strobe and hold phases.
- Sits between the button/pattern logic that produces sample values and the DAC pins, replacing free-running strobe generation with request/acknowledge transactions.

---
 rtl/dac_ctrl_pkg.sv | 29 ++
 rtl/dac_rr_arb.sv | 28 ++
 rtl/dac_write_sched.sv | 166 ++++++++++++++++
 tb/tb_dac_write_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared types and defaults for the dual-channel parallel DAC write scheduler.
package dac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        WRITE = 3'd2,
        HOLD  = 3'd3,
        LOAD  = 3'd4
    } dac_state_e;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    localparam int DEF_SETUP_CYC = 4;
    localparam int DEF_WR_CYC    = 50;
    localparam int DEF_HOLD_CYC  = 30;
    localparam int DEF_LOAD_CYC  = 8;
    localparam int DEF_CNT_W     = 8;

    // Round-robin pick: a sole requester wins, a tie goes to the channel not granted last.
    function automatic logic rr_pick(input logic req_a, input logic req_b, input logic last);
        if (req_a && req_b) begin
            return ~last;
        end
        return req_b ? CH_B : CH_A;
    endfunction

endpackage

// File: rtl/dac_rr_arb.sv
// Two-way round-robin arbiter; the last-grant register advances only when the FSM takes a grant.
module dac_rr_arb
    import dac_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_valid,
    output logic gnt_ch
);

    logic last_q;

    assign gnt_valid = req_a | req_b;
    assign gnt_ch    = rr_pick(req_a, req_b, last_q);

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= CH_B;
        end else if (advance && gnt_valid) begin
            last_q <= gnt_ch;
        end
    end

endmodule

// File: rtl/dac_write_sched.sv
// Request/acknowledge write scheduler for an 8-bit dual-channel parallel DAC.
// Optional macro DAC_SYNC_LOAD_EN: pulse ldacn after a burst instead of holding it low.
//
// state | meaning
// IDLE  | bus released, waiting for a request
// SETUP | csn low, data and channel stable before the write strobe
// WRITE | csn and wrn low
// HOLD  | wrn high, data held; ack on the final cycle
// LOAD  | csn high, ldacn low (DAC_SYNC_LOAD_EN builds only)
module dac_write_sched
    import dac_ctrl_pkg::*;
#(
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WR_CYC    = DEF_WR_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int LOAD_CYC  = DEF_LOAD_CYC,
    parameter int CNT_W     = DEF_CNT_W
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic       busy,
    output logic       dac_csn,
    output logic       dac_wrn,
    output logic       dac_ldacn,
    output logic       dac_a_b,
    output logic [7:0] dac_d
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYC - 1);

    dac_state_e       state_q;
    dac_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             gnt_valid;
    logic             gnt_ch;
    logic             grant;
    logic             ch_d;
    logic [7:0]       d_d;
    logic             ack_fire;

`ifdef DAC_SYNC_LOAD_EN
    logic             other_req;

    // The acked requester still holds req during HOLD, so only the other channel counts as pending.
    assign other_req = (dac_a_b == CH_A) ? req_b : req_a;
`endif

    dac_rr_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .advance   (grant),
        .gnt_valid (gnt_valid),
        .gnt_ch    (gnt_ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (gnt_valid) begin
                    grant   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (cnt_q == WR_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
`ifdef DAC_SYNC_LOAD_EN
                    state_d = other_req ? IDLE : LOAD;
`else
                    state_d = IDLE;
`endif
                end
            end
            LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state so pins change on the same edge as the state.
    always_comb begin
        ch_d     = grant ? gnt_ch : dac_a_b;
        d_d      = dac_d;
        if (grant) begin
            d_d = (gnt_ch == CH_B) ? data_b : data_a;
        end
        ack_fire = (state_d == HOLD) && (cnt_d == HOLD_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_csn   <= 1'b1;
            dac_wrn   <= 1'b1;
            dac_a_b   <= CH_A;
            dac_d     <= '0;
            ack_a     <= 1'b0;
            ack_b     <= 1'b0;
            busy      <= 1'b0;
`ifdef DAC_SYNC_LOAD_EN
            dac_ldacn <= 1'b1;
`else
            dac_ldacn <= 1'b0;
`endif
        end else begin
            dac_csn   <= !((state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD));
            dac_wrn   <= (state_d != WRITE);
            dac_a_b   <= ch_d;
            dac_d     <= d_d;
            ack_a     <= ack_fire && (ch_d == CH_A);
            ack_b     <= ack_fire && (ch_d == CH_B);
            busy      <= (state_d != IDLE);
`ifdef DAC_SYNC_LOAD_EN
            dac_ldacn <= (state_d != LOAD);
`else
            dac_ldacn <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_dac_write_sched.sv
// Self-checking bench for dac_write_sched: vector table plus scoreboard of expected writes.
module tb_dac_write_sched;
    import dac_ctrl_pkg::*;

    localparam int SETUP_CYC = 4;
    localparam int WR_CYC    = 50;
    localparam int HOLD_CYC  = 30;
    localparam int LOAD_CYC  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0, req_b = 1'b0;
    logic [7:0] data_a = 8'h00, data_b = 8'h00;
    logic       ack_a, ack_b, busy, dac_csn, dac_wrn, dac_ldacn, dac_a_b;
    logic [7:0] dac_d;

    logic       m_req_a = 1'b0, m_req_b = 1'b0;
    logic [7:0] m_data_a = 8'h00, m_data_b = 8'h00;
    logic       m_ack_a, m_ack_b, m_busy, m_csn, m_wrn, m_ldacn, m_a_b;
    logic [7:0] m_d;

    always #5 clk = ~clk;

    dac_write_sched #(.SETUP_CYC(SETUP_CYC), .WR_CYC(WR_CYC), .HOLD_CYC(HOLD_CYC),
                      .LOAD_CYC(LOAD_CYC), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .busy(busy), .dac_csn(dac_csn), .dac_wrn(dac_wrn), .dac_ldacn(dac_ldacn),
        .dac_a_b(dac_a_b), .dac_d(dac_d)
    );

    dac_write_sched #(.SETUP_CYC(1), .WR_CYC(1), .HOLD_CYC(1), .LOAD_CYC(1), .CNT_W(8)) u_min (
        .clk(clk), .rst(rst),
        .req_a(m_req_a), .data_a(m_data_a), .ack_a(m_ack_a),
        .req_b(m_req_b), .data_b(m_data_b), .ack_b(m_ack_b),
        .busy(m_busy), .dac_csn(m_csn), .dac_wrn(m_wrn), .dac_ldacn(m_ldacn),
        .dac_a_b(m_a_b), .dac_d(m_d)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       ch;
        logic [7:0] d;
    } txn_t;

    typedef struct {
        logic       ra;
        logic       rb;
        logic [7:0] da;
        logic [7:0] db;
    } vec_t;

    txn_t sb[$];
    logic model_last = CH_B;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: phase lengths per transaction, and each ack compared with the scoreboard head.
    initial begin : monitor
        int   s_cnt, w_cnt, h_cnt;
        logic seen_wr, prev_ack;
        txn_t exp;
        s_cnt = 0; w_cnt = 0; h_cnt = 0; seen_wr = 1'b0; prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_cnt = 0; w_cnt = 0; h_cnt = 0; seen_wr = 1'b0; prev_ack = 1'b0;
            end else begin
                if (!dac_csn) begin
                    if (!dac_wrn) begin
                        seen_wr = 1'b1;
                        w_cnt++;
                    end else if (!seen_wr) begin
                        s_cnt++;
                    end else begin
                        h_cnt++;
                    end
                end
                if (ack_a || ack_b) begin
                    check("ack_exclusive", 32'(ack_a & ack_b), 32'd0);
                    check("ack_single_pulse", 32'(prev_ack), 32'd0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: ack_a=%0b ack_b=%0b with no write pending", ack_a, ack_b);
                    end else begin
                        exp = sb.pop_front();
                        check("ack_channel", 32'(ack_b), 32'(exp.ch));
                        check("dac_a_b_at_ack", 32'(dac_a_b), 32'(exp.ch));
                        check("dac_d_at_ack", 32'(dac_d), 32'(exp.d));
                        check("setup_cycles", s_cnt, SETUP_CYC);
                        check("wrn_low_cycles", w_cnt, WR_CYC);
                        check("hold_cycles", h_cnt, HOLD_CYC);
                    end
                    s_cnt = 0; w_cnt = 0; h_cnt = 0; seen_wr = 1'b0;
                end else if (prev_ack) begin
                    check("csn_after_ack", 32'(dac_csn), 32'd1);
                end
                prev_ack = ack_a | ack_b;
            end
        end
    end

    // Drives one request pattern, predicts grant order, and waits for every ack.
    task automatic run_vec(input vec_t v, output int ld_low);
        int   pend;
        logic first;
        ld_low = 0;
        @(posedge clk); #1;
        data_a = v.da;
        data_b = v.db;
        req_a  = v.ra;
        req_b  = v.rb;
        if (v.ra && v.rb) begin
            first = ~model_last;
            sb.push_back('{ch: first, d: (first == CH_B) ? v.db : v.da});
            sb.push_back('{ch: ~first, d: (first == CH_B) ? v.da : v.db});
            model_last = ~first;
        end else begin
            first = v.rb ? CH_B : CH_A;
            sb.push_back('{ch: first, d: (first == CH_B) ? v.db : v.da});
            model_last = first;
        end
        pend = int'(v.ra) + int'(v.rb);
        for (int c = 0; c < 2000 && pend > 0; c++) begin
            @(negedge clk);
            if (!dac_ldacn) ld_low++;
            if (ack_a && req_a) begin
                @(posedge clk); #1 req_a = 1'b0;
                pend--;
            end else if (ack_b && req_b) begin
                @(posedge clk); #1 req_b = 1'b0;
                pend--;
            end
        end
        if (pend != 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: %0d acks outstanding, expected 0", pend);
            req_a = 1'b0;
            req_b = 1'b0;
            sb.delete();
        end
    endtask

    task automatic settle();
        repeat (LOAD_CYC + 6) @(posedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t vecs[6];
        int   ld_low;
        int   n;
        logic got;

        vecs[0] = '{ra: 1'b1, rb: 1'b0, da: 8'h5A, db: 8'h00};
        vecs[1] = '{ra: 1'b1, rb: 1'b1, da: 8'h11, db: 8'h22};
        vecs[2] = '{ra: 1'b0, rb: 1'b1, da: 8'h00, db: 8'hC3};
        vecs[3] = '{ra: 1'b1, rb: 1'b1, da: 8'hFF, db: 8'h00};
        vecs[4] = '{ra: 1'b1, rb: 1'b0, da: 8'h00, db: 8'hEE};
        vecs[5] = '{ra: 1'b0, rb: 1'b1, da: 8'h77, db: 8'hFF};

        repeat (3) @(negedge clk);
        check("rst_csn", 32'(dac_csn), 32'd1);
        check("rst_wrn", 32'(dac_wrn), 32'd1);
        check("rst_a_b", 32'(dac_a_b), 32'd0);
        check("rst_d", 32'(dac_d), 32'd0);
        check("rst_acks", 32'({ack_a, ack_b}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef DAC_SYNC_LOAD_EN
        check("rst_ldacn", 32'(dac_ldacn), 32'd1);
`else
        check("rst_ldacn", 32'(dac_ldacn), 32'd0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], ld_low);
            settle();
        end

        // Data change during WRITE must not reach the bus.
        @(posedge clk); #1;
        data_a = 8'h3C;
        req_a  = 1'b1;
        sb.push_back('{ch: CH_A, d: 8'h3C});
        model_last = CH_A;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (!dac_wrn) got = 1'b1;
        end
        check("reach_write", 32'(got), 32'd1);
        data_a = 8'hC3;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (ack_a) got = 1'b1;
        end
        check("ack_after_data_change", 32'(got), 32'd1);
        @(posedge clk); #1 req_a = 1'b0;
        settle();

        // Both held continuously: grants alternate, a held req counts as new.
        @(posedge clk); #1;
        data_a = 8'hA1;
        data_b = 8'hB2;
        req_a  = 1'b1;
        req_b  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{ch: ~model_last, d: (~model_last == CH_B) ? 8'hB2 : 8'hA1});
            model_last = ~model_last;
        end
        n = 0;
        for (int c = 0; c < 2000 && n < 3; c++) begin
            @(negedge clk);
            if (ack_a || ack_b) n++;
        end
        check("continuous_ack_count", n, 3);
        @(posedge clk); #1;
        req_a = 1'b0;
        req_b = 1'b0;
        settle();

        // Reset in the middle of WRITE: async return to idle values, no ack.
        @(posedge clk); #1;
        data_a = 8'h77;
        req_a  = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (!dac_wrn) got = 1'b1;
        end
        check("reach_write_before_rst", 32'(got), 32'd1);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_rst_wrn", 32'(dac_wrn), 32'd1);
        check("async_rst_csn", 32'(dac_csn), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ack", 32'({ack_a, ack_b}), 32'd0);
        req_a = 1'b0;
        model_last = CH_B;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        run_vec('{ra: 1'b1, rb: 1'b0, da: 8'h99, db: 8'h00}, ld_low);
        settle();

`ifdef DAC_SYNC_LOAD_EN
        // Back-to-back A/B: no load between writes, one pulse after the second.
        run_vec('{ra: 1'b1, rb: 1'b1, da: 8'h12, db: 8'h34}, ld_low);
        check("ldacn_between_writes", ld_low, 0);
        ld_low = 0;
        repeat (LOAD_CYC + 10) begin
            @(negedge clk);
            if (!dac_ldacn) ld_low++;
        end
        check("ldacn_pulse_len", ld_low, LOAD_CYC);
        settle();
`endif

        // Minimal phase lengths: four cycles from req to ack.
        @(posedge clk); #1;
        m_data_a = 8'hA5;
        m_req_a  = 1'b1;
        n = 0;
        ld_low = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            @(negedge clk);
            if (!m_wrn) ld_low++;
            if (m_ack_a) begin
                n = c;
                check("min_dac_d", 32'(m_d), 32'hA5);
            end
        end
        check("min_req_to_ack", n, 4);
        check("min_wrn_low", ld_low, 1);
        @(posedge clk); #1 m_req_a = 1'b0;
        settle();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
